// File: rtl/game_pkg.sv
// Shared game definitions: actor life states, screen geometry and frame-timer helpers.
package game_pkg;

  typedef enum logic [2:0] {
    SPAWN_WAIT,
    ALIVE,
    FLASH,
    DYING,
    DEAD
  } life_state_t;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  // A timer loaded with N leaves on the (N+1)th frame tick, so a span of F frames loads F-1.
  function automatic logic [7:0] frames_to_load(input int frames);
    if (frames <= 1) return 8'd0;
    if (frames >= 256) return 8'd255;
    return 8'(frames - 1);
  endfunction

  function automatic int spawn_frames(input int base, input int idx);
    int total;
    total = base * (idx + 1);
    return (total > 255) ? 255 : total;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame clock into the Clk domain and emits a
// one-Clk pulse on each of its rising edges.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync_1, sync_2, sync_3;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= frame_clk;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign frame_tick = sync_2 & ~sync_3;

endmodule

// File: rtl/enemy_life_ctrl.sv
// Per-enemy life manager: bullet hit detection, HP, hit-flash, death and
// respawn timing, plus the re-home pulse and hit/kill pulses for other logic.
module enemy_life_ctrl
  import game_pkg::*;
#(
  parameter int id             = 0,
  parameter int MAX_HP         = 3,
  parameter int Width          = 26,
  parameter int Height         = 26,
  parameter int FLASH_FRAMES   = 8,
  parameter int DEATH_FRAMES   = 30,
  parameter int RESPAWN_FRAMES = 120,
  parameter int SPAWN_FRAMES   = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       Bullet_valid,
  input  logic [8:0] Bullet_X,
  input  logic [8:0] Bullet_Y,
  input  logic [8:0] Obj_X_Pos,
  input  logic [8:0] Obj_Y_Pos,
  output logic       is_alive,
  output logic       is_flash,
  output logic       is_dying,
  output logic       Enemy_Reset,
  output logic       hit_ack,
  output logic       kill_pulse,
  output logic [2:0] hp
);

  localparam logic [7:0] SPAWN_LOAD   = frames_to_load(spawn_frames(SPAWN_FRAMES, id));
  localparam logic [7:0] FLASH_LOAD   = frames_to_load(FLASH_FRAMES);
  localparam logic [7:0] DEATH_LOAD   = frames_to_load(DEATH_FRAMES);
  localparam logic [7:0] RESPAWN_LOAD = frames_to_load(RESPAWN_FRAMES);
  localparam logic [2:0] HP_FULL      = 3'(MAX_HP);

  life_state_t state;
  logic [7:0]  timer;
  logic        frame_tick;
  logic        hit;
  logic [9:0]  box_right, box_bottom;

  frame_tick_gen u_frame_tick (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Box edges are widened to 10 bits so boxes near the right/bottom edge never wrap to zero.
  assign box_right  = {1'b0, Obj_X_Pos} + 10'(Width);
  assign box_bottom = {1'b0, Obj_Y_Pos} + 10'(Height);

  assign hit = Bullet_valid
             && ({1'b0, Bullet_X} >= {1'b0, Obj_X_Pos}) && ({1'b0, Bullet_X} < box_right)
             && ({1'b0, Bullet_Y} >= {1'b0, Obj_Y_Pos}) && ({1'b0, Bullet_Y} < box_bottom);

  // Level outputs follow the state one cycle late, so is_alive rises just after Enemy_Reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= SPAWN_WAIT;
      timer       <= SPAWN_LOAD;
      hp          <= HP_FULL;
      is_alive    <= 1'b0;
      is_flash    <= 1'b0;
      is_dying    <= 1'b0;
      Enemy_Reset <= 1'b0;
      hit_ack     <= 1'b0;
      kill_pulse  <= 1'b0;
    end else begin
      is_alive    <= (state == ALIVE) || (state == FLASH);
      is_flash    <= (state == FLASH);
      is_dying    <= (state == DYING);
      Enemy_Reset <= 1'b0;
      hit_ack     <= 1'b0;
      kill_pulse  <= 1'b0;

      case (state)
        SPAWN_WAIT, DEAD: begin
          if (frame_tick) begin
            if (timer == 8'd0) begin
              state       <= ALIVE;
              hp          <= HP_FULL;
              Enemy_Reset <= 1'b1;
            end else begin
              timer <= timer - 8'd1;
            end
          end
        end
        ALIVE: begin
          if (hit) begin
            hit_ack <= 1'b1;
            hp      <= hp - 3'd1;
            if (hp == 3'd1) begin
              kill_pulse <= 1'b1;
              state      <= DYING;
              timer      <= DEATH_LOAD;
            end else begin
              state <= FLASH;
              timer <= FLASH_LOAD;
            end
          end
        end
        FLASH: begin
          if (frame_tick) begin
            if (timer == 8'd0) state <= ALIVE;
            else               timer <= timer - 8'd1;
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (timer == 8'd0) begin
              state <= DEAD;
              timer <= RESPAWN_LOAD;
            end else begin
              timer <= timer - 8'd1;
            end
          end
        end
        default: begin
          state <= SPAWN_WAIT;
          timer <= SPAWN_LOAD;
        end
      endcase
    end
  end

endmodule
